// File: rtl/reg_status_file_if.sv
// ---------------------------------------------------------------------------
// reg_status_file_if
// Groups the dispatch, commit, flush and operand-read signals of the
// architectural register/status file into one bundle.
//   master : decode/ROB side; drives alloc_*, commit_*, flush, rs*_addr and
//            observes rs*_data/busy/tag and pending_cnt
//   slave  : the register file itself
// Signals:
//   alloc_valid/alloc_rd/alloc_tag        dispatch binding of rd to a ROB tag
//   commit_valid/commit_rd/commit_tag/commit_data  ROB head retirement
//   flush                                 drop all in-flight bindings
//   rs1_addr/rs1_data/rs1_busy/rs1_tag    operand read port 1
//   rs2_addr/rs2_data/rs2_busy/rs2_tag    operand read port 2
//   pending_cnt                           number of busy registers
// ---------------------------------------------------------------------------
interface reg_status_file_if #(
    parameter int REG_W  = 5,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 3
);
    logic              alloc_valid;
    logic [REG_W-1:0]  alloc_rd;
    logic [TAG_W-1:0]  alloc_tag;

    logic              commit_valid;
    logic [REG_W-1:0]  commit_rd;
    logic [TAG_W-1:0]  commit_tag;
    logic [DATA_W-1:0] commit_data;

    logic              flush;

    logic [REG_W-1:0]  rs1_addr;
    logic [DATA_W-1:0] rs1_data;
    logic              rs1_busy;
    logic [TAG_W-1:0]  rs1_tag;

    logic [REG_W-1:0]  rs2_addr;
    logic [DATA_W-1:0] rs2_data;
    logic              rs2_busy;
    logic [TAG_W-1:0]  rs2_tag;

    logic [REG_W:0]    pending_cnt;

    modport master (
        output alloc_valid, alloc_rd, alloc_tag,
        output commit_valid, commit_rd, commit_tag, commit_data,
        output flush,
        output rs1_addr, rs2_addr,
        input  rs1_data, rs1_busy, rs1_tag,
        input  rs2_data, rs2_busy, rs2_tag,
        input  pending_cnt
    );

    modport slave (
        input  alloc_valid, alloc_rd, alloc_tag,
        input  commit_valid, commit_rd, commit_tag, commit_data,
        input  flush,
        input  rs1_addr, rs2_addr,
        output rs1_data, rs1_busy, rs1_tag,
        output rs2_data, rs2_busy, rs2_tag,
        output pending_cnt
    );
endinterface

// File: rtl/reg_status_file.sv
// ---------------------------------------------------------------------------
// reg_status_file
// Architectural register file with per-register pending-tag tracking.
// Dispatch marks rd busy and records the ROB tag that will produce it; ROB
// commit writes the result and releases rd only if that tag still owns it.
// Operand reads return a value, or the ROB tag to wait on. Flush drops all
// pending bindings but keeps committed data.
// Ports:
//   clk  clock, all state updates on posedge
//   rst  asynchronous active-high reset
//   bus  reg_status_file_if.slave (alloc/commit/flush/read ports, pending_cnt)
// ---------------------------------------------------------------------------
module reg_status_file #(
    parameter int REG_NUM = 32,
    parameter int REG_W   = 5,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    reg_status_file_if.slave  bus
);

    logic [DATA_W-1:0]  data_q   [REG_NUM];
    logic [TAG_W-1:0]   tag_q    [REG_NUM];
    logic [TAG_W-1:0]   tag_next [REG_NUM];
    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_next;
    logic [REG_W:0]     cnt_next;
    logic [REG_W:0]     cnt_q;

    logic commit_hit;
    logic commit_owns;

    assign commit_hit  = bus.commit_valid && (bus.commit_rd != '0);
    assign commit_owns = commit_hit && busy_q[bus.commit_rd] &&
                         (tag_q[bus.commit_rd] == bus.commit_tag);

    // Next busy/tag state. Flush overrides everything; otherwise the commit
    // release is applied first so a same-cycle alloc to the same rd wins.
    always_comb begin
        busy_next = busy_q;
        for (int i = 0; i < REG_NUM; i++) begin
            tag_next[i] = tag_q[i];
        end
        if (bus.flush) begin
            busy_next = '0;
            for (int i = 0; i < REG_NUM; i++) begin
                tag_next[i] = '0;
            end
        end else begin
            if (commit_owns) begin
                busy_next[bus.commit_rd] = 1'b0;
            end
            if (bus.alloc_valid && (bus.alloc_rd != '0)) begin
                busy_next[bus.alloc_rd] = 1'b1;
                tag_next[bus.alloc_rd]  = bus.alloc_tag;
            end
        end
    end

    // Popcount of the next busy vector so pending_cnt moves with busy.
    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            cnt_next = cnt_next + {{REG_W{1'b0}}, busy_next[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_next;
            cnt_q  <= cnt_next;
            for (int i = 0; i < REG_NUM; i++) begin
                tag_q[i] <= tag_next[i];
            end
        end
    end

    // Commit data is written unconditionally, even on flush or when a newer
    // owner holds rd: the architectural value must still advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                data_q[i] <= '0;
            end
        end else if (commit_hit) begin
            data_q[bus.commit_rd] <= bus.commit_data;
        end
    end

    // Read port 1: a commit from the owning tag is bypassed so the consumer
    // does not stall a cycle waiting on a value already on the commit bus.
    always_comb begin
        bus.rs1_data = '0;
        bus.rs1_busy = 1'b0;
        bus.rs1_tag  = '0;
        if (bus.rs1_addr != '0) begin
            bus.rs1_data = data_q[bus.rs1_addr];
            if (busy_q[bus.rs1_addr]) begin
                if (commit_owns && (bus.commit_rd == bus.rs1_addr)) begin
                    bus.rs1_data = bus.commit_data;
                end else begin
                    bus.rs1_busy = 1'b1;
                    bus.rs1_tag  = tag_q[bus.rs1_addr];
                end
            end
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        bus.rs2_data = '0;
        bus.rs2_busy = 1'b0;
        bus.rs2_tag  = '0;
        if (bus.rs2_addr != '0) begin
            bus.rs2_data = data_q[bus.rs2_addr];
            if (busy_q[bus.rs2_addr]) begin
                if (commit_owns && (bus.commit_rd == bus.rs2_addr)) begin
                    bus.rs2_data = bus.commit_data;
                end else begin
                    bus.rs2_busy = 1'b1;
                    bus.rs2_tag  = tag_q[bus.rs2_addr];
                end
            end
        end
    end

    assign bus.pending_cnt = cnt_q;

endmodule

// File: tb/tb_reg_status_file.sv
// ---------------------------------------------------------------------------
// tb_reg_status_file
// Self-checking bench for reg_status_file: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the register/status file.
// ---------------------------------------------------------------------------
module tb_reg_status_file;

    logic clk;
    logic rst;

    reg_status_file_if #(.REG_W(5), .DATA_W(32), .TAG_W(3)) bus ();

    reg_status_file #(
        .REG_NUM(32), .REG_W(5), .DATA_W(32), .TAG_W(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 0;

    // Behavioural model state: what each register architecturally holds.
    logic [31:0] m_data [32];
    bit          m_busy [32];
    logic [2:0]  m_tag  [32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model update: flush discards bindings; otherwise a commit releases its
    // register only if its tag still owns it, then an alloc claims its rd.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_data[i] = '0;
                m_busy[i] = 0;
                m_tag[i]  = '0;
            end
        end else begin
            int crd;
            int ard;
            crd = int'(bus.commit_rd);
            ard = int'(bus.alloc_rd);
            if (bus.commit_valid && crd != 0) m_data[crd] = bus.commit_data;
            if (bus.flush) begin
                for (int i = 0; i < 32; i++) begin
                    m_busy[i] = 0;
                    m_tag[i]  = '0;
                end
            end else begin
                if (bus.commit_valid && crd != 0 && m_busy[crd] && m_tag[crd] == bus.commit_tag)
                    m_busy[crd] = 0;
                if (bus.alloc_valid && ard != 0) begin
                    m_busy[ard] = 1;
                    m_tag[ard]  = bus.alloc_tag;
                end
            end
        end
    end

    function automatic void exp_read(input logic [4:0] addr, output logic [31:0] d,
                                     output logic b, output logic [2:0] t);
        int a;
        a = int'(addr);
        d = '0; b = 0; t = '0;
        if (a != 0) begin
            d = m_data[a];
            if (m_busy[a]) begin
                if (bus.commit_valid && int'(bus.commit_rd) == a && m_tag[a] == bus.commit_tag)
                    d = bus.commit_data;
                else begin
                    b = 1;
                    t = m_tag[a];
                end
            end
        end
    endfunction

    function automatic int exp_pending();
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) if (m_busy[i]) c++;
        return c;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] d;
            logic        b;
            logic [2:0]  t;
            exp_read(bus.rs1_addr, d, b, t);
            checkOutput("cyc_rs1_data", bus.rs1_data, d);
            checkOutput("cyc_rs1_busy", {31'b0, bus.rs1_busy}, {31'b0, b});
            checkOutput("cyc_rs1_tag",  {29'b0, bus.rs1_tag},  {29'b0, t});
            exp_read(bus.rs2_addr, d, b, t);
            checkOutput("cyc_rs2_data", bus.rs2_data, d);
            checkOutput("cyc_rs2_busy", {31'b0, bus.rs2_busy}, {31'b0, b});
            checkOutput("cyc_rs2_tag",  {29'b0, bus.rs2_tag},  {29'b0, t});
            checkOutput("cyc_pending",  {26'b0, bus.pending_cnt}, 32'(exp_pending()));
        end
    end

    // Drives one cycle of inputs just after a posedge, then returns mid-cycle
    // so the combinational reads for this input set can be inspected.
    task automatic applyStimulus(input bit av, input logic [4:0] ard, input logic [2:0] atag,
                                 input bit cv, input logic [4:0] crd, input logic [2:0] ctag,
                                 input logic [31:0] cdata, input bit fl,
                                 input logic [4:0] r1, input logic [4:0] r2);
        @(posedge clk);
        #1;
        bus.alloc_valid  = av;  bus.alloc_rd  = ard; bus.alloc_tag  = atag;
        bus.commit_valid = cv;  bus.commit_rd = crd; bus.commit_tag = ctag;
        bus.commit_data  = cdata;
        bus.flush        = fl;
        bus.rs1_addr     = r1;  bus.rs2_addr  = r2;
        @(negedge clk);
        #1;
    endtask

    task automatic idleRead(input logic [4:0] r1, input logic [4:0] r2);
        applyStimulus(0, 5'd0, 3'd0, 0, 5'd0, 3'd0, 32'h0, 0, r1, r2);
    endtask

    task automatic checkRs1(input string name, input logic [31:0] d, input logic b, input logic [2:0] t);
        checkOutput({name, "_data"}, bus.rs1_data, d);
        checkOutput({name, "_busy"}, {31'b0, bus.rs1_busy}, {31'b0, b});
        checkOutput({name, "_tag"},  {29'b0, bus.rs1_tag},  {29'b0, t});
    endtask

    task automatic randomCycles(input int n);
        for (int k = 0; k < n; k++) begin
            logic [4:0] ard, crd;
            logic [2:0] ctag;
            ard  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            crd  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            ctag = ($urandom_range(0, 1) == 0) ? m_tag[crd] : 3'($urandom_range(0, 7));
            applyStimulus(1'($urandom_range(0, 1)), ard, 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), crd, ctag, $urandom(),
                          ($urandom_range(0, 31) == 0),
                          ($urandom_range(0, 1) == 0) ? crd : 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 7)));
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.alloc_valid = 0; bus.alloc_rd = '0; bus.alloc_tag = '0;
        bus.commit_valid = 0; bus.commit_rd = '0; bus.commit_tag = '0; bus.commit_data = '0;
        bus.flush = 0; bus.rs1_addr = '0; bus.rs2_addr = '0;
        #12;
        rst = 1'b0;
        #1;

        // Reset state across all registers.
        for (int i = 1; i < 32; i++) begin
            bus.rs1_addr = 5'(i);
            bus.rs2_addr = 5'(32 - i);
            #1;
            checkRs1("reset_rs1", 32'h0, 1'b0, 3'd0);
            checkOutput("reset_rs2_busy", {31'b0, bus.rs2_busy}, 32'h0);
        end
        checkOutput("reset_pending", {26'b0, bus.pending_cnt}, 32'h0);
        chk_en = 1;

        // Allocate then commit with bypass.
        applyStimulus(1, 5'd5, 3'd3, 0, 5'd0, 3'd0, 32'h0, 0, 5'd0, 5'd0);
        idleRead(5'd5, 5'd0);
        checkRs1("alloc_x5", 32'h0, 1'b1, 3'd3);
        checkOutput("alloc_pending", {26'b0, bus.pending_cnt}, 32'd1);
        applyStimulus(0, 5'd0, 3'd0, 1, 5'd5, 3'd3, 32'hDEAD, 0, 5'd5, 5'd0);
        checkRs1("bypass_x5", 32'hDEAD, 1'b0, 3'd0);
        idleRead(5'd5, 5'd0);
        checkRs1("commit_x5", 32'hDEAD, 1'b0, 3'd0);
        checkOutput("commit_pending", {26'b0, bus.pending_cnt}, 32'd0);

        // Stale commit must not release a newer owner.
        applyStimulus(1, 5'd7, 3'd1, 0, 5'd0, 3'd0, 32'h0, 0, 5'd0, 5'd0);
        applyStimulus(1, 5'd7, 3'd4, 0, 5'd0, 3'd0, 32'h0, 0, 5'd0, 5'd0);
        applyStimulus(0, 5'd0, 3'd0, 1, 5'd7, 3'd1, 32'h11, 0, 5'd7, 5'd0);
        checkRs1("stale_bypass_x7", 32'h0, 1'b1, 3'd4);
        idleRead(5'd7, 5'd0);
        checkRs1("stale_x7", 32'h11, 1'b1, 3'd4);

        // Same-cycle alloc and owning commit on one register: alloc wins.
        applyStimulus(1, 5'd9, 3'd6, 0, 5'd0, 3'd0, 32'h0, 0, 5'd0, 5'd0);
        applyStimulus(1, 5'd9, 3'd2, 1, 5'd9, 3'd6, 32'h55, 0, 5'd0, 5'd0);
        idleRead(5'd9, 5'd0);
        checkRs1("alloc_wins_x9", 32'h55, 1'b1, 3'd2);
        checkOutput("pending_x7_x9", {26'b0, bus.pending_cnt}, 32'd2);

        // Flush with same-cycle commit and alloc.
        applyStimulus(1, 5'd3, 3'd0, 0, 5'd0, 3'd0, 32'h0, 0, 5'd0, 5'd0);
        applyStimulus(1, 5'd4, 3'd1, 0, 5'd0, 3'd0, 32'h0, 0, 5'd0, 5'd0);
        applyStimulus(1, 5'd6, 3'd2, 0, 5'd0, 3'd0, 32'h0, 0, 5'd0, 5'd0);
        applyStimulus(1, 5'd8, 3'd5, 1, 5'd3, 3'd0, 32'h77, 1, 5'd0, 5'd0);
        idleRead(5'd3, 5'd8);
        checkRs1("flush_x3", 32'h77, 1'b0, 3'd0);
        checkOutput("flush_x8_busy", {31'b0, bus.rs2_busy}, 32'h0);
        checkOutput("flush_pending", {26'b0, bus.pending_cnt}, 32'd0);

        // x0 is hardwired to zero.
        applyStimulus(1, 5'd0, 3'd1, 1, 5'd0, 3'd1, 32'hFFFF, 0, 5'd0, 5'd0);
        checkRs1("x0_same", 32'h0, 1'b0, 3'd0);
        idleRead(5'd0, 5'd0);
        checkRs1("x0_after", 32'h0, 1'b0, 3'd0);

        // Randomized traffic.
        randomCycles(3000);

        // Asynchronous reset mid-stream.
        applyStimulus(1, 5'd2, 3'd7, 0, 5'd0, 3'd0, 32'h0, 0, 5'd2, 5'd0);
        idleRead(5'd2, 5'd0);
        checkRs1("pre_rst_x2", m_data[2], 1'b1, 3'd7);
        #1;
        rst = 1'b1;
        #1;
        checkRs1("mid_rst_x2", 32'h0, 1'b0, 3'd0);
        checkOutput("mid_rst_pending", {26'b0, bus.pending_cnt}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        randomCycles(500);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
